// File: rtl/plab4_net_router_adaptive_input_terminal_wh_ctrl_pkg.sv
// Shared route/request encodings and FSM states for the wormhole terminal input control.
package plab4_net_router_adaptive_input_terminal_wh_ctrl_pkg;

  // Route value doubles as the bit index into reqs/grants.
  typedef enum logic [1:0] {
    ROUTE_PREV = 2'd0,
    ROUTE_TERM = 2'd1,
    ROUTE_NEXT = 2'd2
  } route_e;

  localparam int REQ_PREV = 0;
  localparam int REQ_TERM = 1;
  localparam int REQ_NEXT = 2;

  typedef enum logic {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  function automatic route_e route_opposite(input route_e r);
    case (r)
      ROUTE_PREV: return ROUTE_NEXT;
      ROUTE_NEXT: return ROUTE_PREV;
      default:    return r;
    endcase
  endfunction

  function automatic logic [2:0] route_onehot(input route_e r);
    logic [2:0] oh;
    oh = 3'b000;
    case (r)
      ROUTE_PREV: oh[REQ_PREV] = 1'b1;
      ROUTE_TERM: oh[REQ_TERM] = 1'b1;
      ROUTE_NEXT: oh[REQ_NEXT] = 1'b1;
      default:    oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/plab4_net_router_adaptive_input_terminal_wh_ctrl_if.sv
// Queue-front / output-arbiter signal bundle seen by the terminal input control.
interface plab4_net_router_adaptive_input_terminal_wh_ctrl_if #(
  parameter int p_dest_nbits          = 3,
  parameter int p_len_nbits           = 4,
  parameter int p_num_free_nbits      = 2,
  parameter int p_num_free_chan_nbits = 2
);
  logic [p_dest_nbits-1:0]          dest;
  logic [p_len_nbits-1:0]           len;
  logic                             in_val;
  logic                             in_rdy;
  logic [p_num_free_nbits-1:0]      num_free0;
  logic [p_num_free_nbits-1:0]      num_free2;
  logic [p_num_free_chan_nbits-1:0] num_free_chan0;
  logic [p_num_free_chan_nbits-1:0] num_free_chan2;
  logic [2:0]                       reqs;
  logic [2:0]                       grants;
  logic                             pkt_active;

  modport master (
    output dest, len, in_val, num_free0, num_free2,
           num_free_chan0, num_free_chan2, grants,
    input  in_rdy, reqs, pkt_active
  );

  modport slave (
    input  dest, len, in_val, num_free0, num_free2,
           num_free_chan0, num_free_chan2, grants,
    output in_rdy, reqs, pkt_active
  );
endinterface

// File: rtl/plab4_net_router_adaptive_input_terminal_wh_ctrl_route.sv
// Minimal-hop ring route; equidistant destinations pick the direction with more channel credit.
module plab4_net_AdaptiveRouteCompute
  import plab4_net_router_adaptive_input_terminal_wh_ctrl_pkg::*;
#(
  parameter int p_router_id      = 0,
  parameter int p_num_routers    = 8,
  parameter int p_num_free_nbits = 2,
  parameter int c_dest_nbits     = $clog2(p_num_routers)
) (
  input  logic [c_dest_nbits-1:0]     dest,
  input  logic [p_num_free_nbits-1:0] num_free_chan0,
  input  logic [p_num_free_nbits-1:0] num_free_chan2,
  output route_e                      route
);
  localparam int W = c_dest_nbits + 1;
  localparam logic [W-1:0] N  = W'(p_num_routers);
  localparam logic [W-1:0] ID = W'(p_router_id);

  logic [W-1:0] sum, fwd, bwd;

  always_comb begin
    sum   = {1'b0, dest} + N - ID;
    fwd   = (sum >= N) ? sum - N : sum;
    bwd   = N - fwd;
    route = ROUTE_NEXT;
    if (fwd == '0)
      route = ROUTE_TERM;
    else if (bwd < fwd)
      route = ROUTE_PREV;
    else if (bwd == fwd && num_free_chan2 > num_free_chan0)
      route = ROUTE_PREV;
  end
endmodule

// File: rtl/plab4_net_router_adaptive_input_terminal_wh_ctrl.sv
// Terminal-port input control: per-packet adaptive route lock, head-only bubble check,
// and starvation escape to the opposite ring direction.
module plab4_net_router_adaptive_input_terminal_wh_ctrl
  import plab4_net_router_adaptive_input_terminal_wh_ctrl_pkg::*;
#(
  parameter int p_router_id           = 0,
  parameter int p_num_routers         = 8,
  parameter int p_num_free_nbits      = 2,
  parameter int p_num_free_chan_nbits = 2,
  parameter int p_len_nbits           = 4,
  parameter int p_bubble              = 2,
  parameter int p_starve_nbits        = 4,
  parameter int p_starve_thresh       = 8
) (
  input logic clk,
  input logic reset,
  plab4_net_router_adaptive_input_terminal_wh_ctrl_if.slave ifc
);
  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam logic [p_len_nbits-1:0]    LEN_ONE   = p_len_nbits'(1);
  localparam logic [p_starve_nbits-1:0] THRESH_M1 = p_starve_nbits'(p_starve_thresh - 1);

  state_e                     state_q, state_d;
  route_e                     route_q, route_d;
  logic [p_len_nbits-1:0]     rem_q, rem_d;
  logic [p_starve_nbits-1:0]  cnt_q, cnt_d;
  logic                       esc_q, esc_d;

  route_e                      comp_route, eff_route, tgt;
  logic [p_num_free_nbits-1:0] free_n;
  logic                        room;
  logic [2:0]                  reqs;
  logic                        xfer;

  plab4_net_AdaptiveRouteCompute #(
    .p_router_id      (p_router_id),
    .p_num_routers    (p_num_routers),
    .p_num_free_nbits (p_num_free_chan_nbits)
  ) u_route (
    .dest           (ifc.dest[c_dest_nbits-1:0]),
    .num_free_chan0 (ifc.num_free_chan0),
    .num_free_chan2 (ifc.num_free_chan2),
    .route          (comp_route)
  );

  // Head flits need a bubble of free slots to enter the ring; body flits need only one.
  always_comb begin
    eff_route = comp_route;
    if (esc_q && comp_route != ROUTE_TERM) eff_route = route_opposite(comp_route);
    tgt    = (state_q == ST_BODY) ? route_q : eff_route;
    free_n = (tgt == ROUTE_PREV) ? ifc.num_free2 : ifc.num_free0;
    room   = (state_q == ST_BODY) ? (free_n != '0) : (int'(free_n) >= p_bubble);
    reqs   = 3'b000;
    if (!reset && ifc.in_val && (tgt == ROUTE_TERM || room)) reqs = route_onehot(tgt);
    xfer   = |(reqs & ifc.grants);
  end

  assign ifc.reqs       = reqs;
  assign ifc.in_rdy     = xfer;
  assign ifc.pkt_active = (state_q == ST_BODY);

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    esc_d   = esc_q;
    case (state_q)
      ST_HEAD: begin
        if (xfer) begin
          cnt_d = '0;
          esc_d = 1'b0;
          if (ifc.len > LEN_ONE) begin
            state_d = ST_BODY;
            route_d = eff_route;
            rem_d   = ifc.len - LEN_ONE;
          end
        end else if (!ifc.in_val) begin
          cnt_d = '0;
          esc_d = 1'b0;
        end else if (eff_route != ROUTE_TERM) begin
          // Escape fires once; further blocking while escaped only saturates the count.
          if (!esc_q && cnt_q == THRESH_M1) begin
            esc_d = 1'b1;
            cnt_d = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BODY: begin
        if (xfer) begin
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = ST_HEAD;
        end
      end
      default: state_d = ST_HEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HEAD;
      route_q <= ROUTE_TERM;
      rem_q   <= '0;
      cnt_q   <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      esc_q   <= esc_d;
    end
  end
endmodule

// File: tb/tb_plab4_net_router_adaptive_input_terminal_wh_ctrl.sv
// Bench: fixed vectors, hand sequences for wormhole/starvation/reset, and random traffic
// against a packet-level reference model.
module tb_plab4_net_router_adaptive_input_terminal_wh_ctrl;
  localparam int ID     = 0;
  localparam int N      = 8;
  localparam int BUBBLE = 2;
  localparam int THRESH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plab4_net_router_adaptive_input_terminal_wh_ctrl_if #(
    .p_dest_nbits(3), .p_len_nbits(4), .p_num_free_nbits(2), .p_num_free_chan_nbits(2)
  ) ifc ();

  plab4_net_router_adaptive_input_terminal_wh_ctrl #(
    .p_router_id(ID), .p_num_routers(N), .p_num_free_nbits(2), .p_num_free_chan_nbits(2),
    .p_len_nbits(4), .p_bubble(BUBBLE), .p_starve_nbits(4), .p_starve_thresh(THRESH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  int n_chk = 0;
  int n_err = 0;

  // Packet-level model: in-packet flag, locked port, flits left, blocked-cycle wait, escape flag.
  bit m_body;
  int m_route, m_left, m_wait;
  bit m_esc;

  function automatic int route_of(int d, int c0, int c2);
    int fwd = (d - ID + N) % N;
    int bwd = N - fwd;
    if (fwd == 0) return 1;
    if (fwd < bwd) return 2;
    if (bwd < fwd) return 0;
    return (c2 > c0) ? 0 : 2;
  endfunction

  function automatic int head_route();
    int r = route_of(int'(ifc.dest), int'(ifc.num_free_chan0), int'(ifc.num_free_chan2));
    if (m_esc && r != 1) r = 2 - r;
    return r;
  endfunction

  function automatic int model_reqs();
    int r, need, free;
    if (reset || !ifc.in_val) return 0;
    if (m_body) begin r = m_route; need = 1; end
    else begin r = head_route(); need = BUBBLE; end
    free = (r == 0) ? int'(ifc.num_free2) : (r == 2) ? int'(ifc.num_free0) : need;
    return (free >= need) ? (1 << r) : 0;
  endfunction

  task automatic model_update(input bit x);
    int r;
    if (reset) begin
      m_body = 0; m_left = 0; m_wait = 0; m_esc = 0;
    end else if (!m_body) begin
      r = head_route();
      if (x) begin
        m_wait = 0; m_esc = 0;
        if (int'(ifc.len) > 1) begin m_body = 1; m_route = r; m_left = int'(ifc.len) - 1; end
      end else if (!ifc.in_val) begin
        m_wait = 0; m_esc = 0;
      end else if (r != 1) begin
        m_wait++;
        if (m_wait == THRESH && !m_esc) begin m_esc = 1; m_wait = 0; end
      end
    end else if (x) begin
      m_left--;
      if (m_left == 0) m_body = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input int l, input int v, input int f0, input int f2,
                       input int c0, input int c2, input int g);
    ifc.dest = 3'(d); ifc.len = 4'(l); ifc.in_val = 1'(v);
    ifc.num_free0 = 2'(f0); ifc.num_free2 = 2'(f2);
    ifc.num_free_chan0 = 2'(c0); ifc.num_free_chan2 = 2'(c2);
    ifc.grants = 3'(g);
  endtask

  // Checks one cycle against the model and, where given (>=0), against explicit values.
  task automatic step(input string nm, input int er, input int erdy, input int epa);
    int mr;
    bit mx;
    #1;
    mr = model_reqs();
    mx = ifc.in_val && ((mr & int'(ifc.grants)) != 0);
    chk({nm, " reqs/model"}, int'(ifc.reqs), mr);
    chk({nm, " in_rdy/model"}, int'(ifc.in_rdy), int'(mx));
    chk({nm, " pkt_active/model"}, int'(ifc.pkt_active), int'(m_body));
    if (er >= 0)   chk({nm, " reqs"}, int'(ifc.reqs), er);
    if (erdy >= 0) chk({nm, " in_rdy"}, int'(ifc.in_rdy), erdy);
    if (epa >= 0)  chk({nm, " pkt_active"}, int'(ifc.pkt_active), epa);
    model_update(mx);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.in_val = 1'b0;
    step("idle", 0, 0, 0);
  endtask

  typedef struct {
    int d, l, v, f0, f2, c0, c2, g;
    int er, erdy;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 1, 1, 0, 0, 0, 0, 3'b010, 3'b010, 1};  // to self
    tbl[1] = '{0, 1, 0, 3, 3, 0, 0, 3'b111, 3'b000, 0};  // not valid
    tbl[2] = '{2, 1, 1, 1, 3, 0, 0, 3'b100, 3'b000, 0};  // next, no bubble
    tbl[3] = '{2, 1, 1, 2, 0, 0, 0, 3'b100, 3'b100, 1};  // next, bubble met
    tbl[4] = '{6, 1, 1, 0, 2, 0, 0, 3'b001, 3'b001, 1};  // prev, bubble met
    tbl[5] = '{6, 1, 1, 3, 1, 0, 0, 3'b001, 3'b000, 0};  // prev, no bubble
    tbl[6] = '{4, 1, 1, 0, 3, 1, 3, 3'b001, 3'b001, 1};  // tie -> prev by credit
    tbl[7] = '{4, 1, 1, 3, 3, 2, 2, 3'b001, 3'b100, 0};  // tie equal -> next; wrong grant
    tbl[8] = '{4, 1, 1, 2, 3, 3, 1, 3'b111, 3'b100, 1};  // tie -> next by credit
    tbl[9] = '{0, 0, 1, 0, 0, 0, 0, 3'b000, 3'b010, 0};  // term not granted

    m_body = 0; m_route = 1; m_left = 0; m_wait = 0; m_esc = 0;
    reset = 1'b1;
    drive(2, 4, 1, 3, 3, 3, 3, 3'b111);
    @(posedge clk);
    #1;
    step("reset0", 0, 0, 0);
    step("reset1", 0, 0, 0);
    reset = 1'b0;
    idle();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].d, tbl[i].l, tbl[i].v, tbl[i].f0, tbl[i].f2, tbl[i].c0, tbl[i].c2, tbl[i].g);
      step($sformatf("vec%0d", i), tbl[i].er, tbl[i].erdy, 0);
      idle();
    end

    // 4-flit packet on NEXT, body ignores dest/credit changes.
    drive(2, 4, 1, 2, 0, 1, 1, 3'b100);
    step("wh_head", 3'b100, 1, 0);
    ifc.num_free0 = 2'd1; ifc.dest = 3'd6; ifc.len = 4'd1;
    ifc.num_free_chan0 = 2'd0; ifc.num_free_chan2 = 2'd3;
    step("wh_body1", 3'b100, 1, 1);
    ifc.num_free0 = 2'd0;
    step("wh_stall", 3'b000, 0, 1);
    ifc.num_free0 = 2'd1;
    step("wh_body2", 3'b100, 1, 1);
    step("wh_body3", 3'b100, 1, 1);
    ifc.in_val = 1'b0;
    step("wh_done", 3'b000, 0, 0);

    // Starvation on PREV escapes to NEXT on cycle 9.
    drive(6, 1, 1, 2, 3, 0, 0, 3'b000);
    for (int i = 0; i < THRESH; i++) step("starve_wait", 3'b001, 0, 0);
    step("starve_esc", 3'b100, 0, 0);
    ifc.grants = 3'b100;
    step("esc_grant", 3'b100, 1, 0);
    ifc.grants = 3'b000;
    step("esc_clr", 3'b001, 0, 0);
    idle();

    // Grant arriving on the threshold cycle wins over escape.
    drive(6, 1, 1, 2, 3, 0, 0, 3'b000);
    for (int i = 0; i < THRESH - 1; i++) step("coin_wait", 3'b001, 0, 0);
    ifc.grants = 3'b001;
    step("coin_grant", 3'b001, 1, 0);
    ifc.grants = 3'b000;
    step("coin_noesc", 3'b001, 0, 0);
    idle();

    // Reset in the middle of a packet.
    drive(2, 3, 1, 2, 0, 0, 0, 3'b100);
    step("rst_head", 3'b100, 1, 0);
    step("rst_body", 3'b100, 1, 1);
    reset = 1'b1;
    step("rst_hold", 3'b000, 0, -1);
    reset = 1'b0;
    ifc.len = 4'd1;
    step("rst_after", 3'b100, 1, 0);
    idle();

    // Random traffic; alternate low/high grant phases to reach starvation.
    for (int i = 0; i < 3000; i++) begin
      int gp;
      reset = ($urandom_range(0, 199) == 0);
      gp = ((i / 60) % 2 == 1) ? 5 : 60;
      drive($urandom_range(0, 7), $urandom_range(0, 4), ($urandom_range(0, 9) != 0),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 99) < gp)
        ifc.grants = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(model_reqs());
      else
        ifc.grants = 3'b000;
      step("rand", -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
